// File: rtl/iter_alu_pkg.sv
// Shared types for the iterative execute-stage ALU: operation encoding and FSM states.
package iter_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11,
        OP_MULU = 4'd12,
        OP_DIV  = 4'd13,
        OP_DIVU = 4'd14
    } iter_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } iter_state_t;

    // Encodings ADD..SLTU complete in a single cycle; 15 is unassigned.
    function automatic logic is_single_cycle(input iter_op_t op);
        return op <= OP_SLTU;
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/result bundle between the pipeline (master) and the iterative ALU (slave).
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    import iter_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    iter_op_t         op;
    logic [WIDTH-1:0] portA;
    logic [WIDTH-1:0] portB;
    logic             out_valid;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, op, portA, portB,
        input  in_ready, out_valid, result_lo, result_hi,
        input  zero, negative, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, op, portA, portB,
        output in_ready, out_valid, result_lo, result_hi,
        output zero, negative, overflow, div_by_zero
    );

endinterface

// File: rtl/iter_alu_alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub, shifts and compares; purely combinational.
module alu_comb
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  iter_op_t         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] and_w, or_w, xor_w, nor_w;
    logic [WIDTH-1:0] sum_w, diff_w;
    logic [SHW-1:0]   shamt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_w[gi] = a[gi] & b[gi];
            assign or_w[gi]  = a[gi] | b[gi];
            assign xor_w[gi] = a[gi] ^ b[gi];
            assign nor_w[gi] = ~(a[gi] | b[gi]);
        end
    endgenerate

    assign sum_w  = a + b;
    assign diff_w = a - b;
    assign shamt  = a[SHW-1:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum_w;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff_w;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = and_w;
            OP_OR:   result = or_w;
            OP_XOR:  result = xor_w;
            OP_NOR:  result = nor_w;
            OP_SLL:  result = b << shamt;
            OP_SRL:  result = b >> shamt;
            OP_SRA:  result = $unsigned($signed(b) >>> shamt);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute-stage ALU: single-cycle ops via alu_comb, shift-add multiply and
// restoring divide on operand magnitudes with a final sign-fix cycle.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       CLK,
    input logic       nRST,
    iter_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    iter_state_t      state_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg, opd_reg;
    logic             is_div_reg, signed_reg, neg_lo_reg, neg_hi_reg;

    logic             in_ready_reg, out_valid_reg;
    logic [WIDTH-1:0] result_lo_reg, result_hi_reg;
    logic             zero_reg, negative_reg, overflow_reg, dbz_reg;

    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .op       (bus.op),
        .a        (bus.portA),
        .b        (bus.portB),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    // Operand magnitudes loaded into the iterative datapath on accept.
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        op_signed = (bus.op == OP_MUL) || (bus.op == OP_DIV);
        a_neg     = op_signed & bus.portA[WIDTH-1];
        b_neg     = op_signed & bus.portB[WIDTH-1];
        a_mag     = a_neg ? -bus.portA : bus.portA;
        b_mag     = b_neg ? -bus.portB : bus.portB;
    end

    // Multiply step: hi accumulates the multiplicand, the product shifts down through lo.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
    // Divide step: hi holds the partial remainder, quotient bits shift into lo.
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] div_hi_next, div_lo_next;

    always_comb begin
        mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

        rem_shift   = {hi_reg, lo_reg[WIDTH-1]};
        rem_diff    = rem_shift - {1'b0, opd_reg};
        q_bit       = ~rem_diff[WIDTH];
        div_hi_next = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        div_lo_next = {lo_reg[WIDTH-2:0], q_bit};
    end

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_lo, fix_hi;
    logic               fix_ovf;

    always_comb begin
        prod     = {hi_reg, lo_reg};
        prod_fix = neg_lo_reg ? -prod : prod;
        if (is_div_reg) begin
            fix_lo  = neg_lo_reg ? -lo_reg : lo_reg;
            fix_hi  = neg_hi_reg ? -hi_reg : hi_reg;
            // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
            fix_ovf = signed_reg & ~neg_lo_reg & lo_reg[WIDTH-1];
        end else begin
            fix_lo  = prod_fix[WIDTH-1:0];
            fix_hi  = prod_fix[2*WIDTH-1:WIDTH];
            fix_ovf = signed_reg && (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            opd_reg       <= '0;
            is_div_reg    <= 1'b0;
            signed_reg    <= 1'b0;
            neg_lo_reg    <= 1'b0;
            neg_hi_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b0;
            negative_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        case (bus.op)
                            OP_MUL, OP_MULU: begin
                                hi_reg     <= '0;
                                lo_reg     <= b_mag;
                                opd_reg    <= a_mag;
                                is_div_reg <= 1'b0;
                                signed_reg <= op_signed;
                                neg_lo_reg <= a_neg ^ b_neg;
                                neg_hi_reg <= 1'b0;
                                cnt_reg    <= '0;
                                state_reg  <= ITER;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.portB == '0) begin
                                    result_lo_reg <= '1;
                                    result_hi_reg <= bus.portA;
                                    zero_reg      <= 1'b0;
                                    negative_reg  <= 1'b1;
                                    overflow_reg  <= 1'b0;
                                    dbz_reg       <= 1'b1;
                                    out_valid_reg <= 1'b1;
                                    state_reg     <= DONE;
                                end else begin
                                    hi_reg     <= '0;
                                    lo_reg     <= a_mag;
                                    opd_reg    <= b_mag;
                                    is_div_reg <= 1'b1;
                                    signed_reg <= op_signed;
                                    neg_lo_reg <= a_neg ^ b_neg;
                                    neg_hi_reg <= a_neg;
                                    cnt_reg    <= '0;
                                    state_reg  <= ITER;
                                end
                            end
                            default: begin
                                result_lo_reg <= alu_result;
                                result_hi_reg <= '0;
                                zero_reg      <= is_single_cycle(bus.op) && (alu_result == '0);
                                negative_reg  <= alu_result[WIDTH-1];
                                overflow_reg  <= alu_ovf;
                                dbz_reg       <= 1'b0;
                                out_valid_reg <= 1'b1;
                                state_reg     <= DONE;
                            end
                        endcase
                    end
                end
                ITER: begin
                    hi_reg  <= is_div_reg ? div_hi_next : mul_hi_next;
                    lo_reg  <= is_div_reg ? div_lo_next : mul_lo_next;
                    cnt_reg <= cnt_reg + SHW'(1);
                    if (cnt_reg == SHW'(WIDTH-1))
                        state_reg <= FIX;
                end
                FIX: begin
                    result_lo_reg <= fix_lo;
                    result_hi_reg <= fix_hi;
                    zero_reg      <= (fix_lo == '0);
                    negative_reg  <= fix_lo[WIDTH-1];
                    overflow_reg  <= fix_ovf;
                    dbz_reg       <= 1'b0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.result_lo   = result_lo_reg;
    assign bus.result_hi   = result_hi_reg;
    assign bus.zero        = zero_reg;
    assign bus.negative    = negative_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_iter_alu;
    import iter_alu_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    iter_alu_if #(.WIDTH(32)) b32 ();
    iter_alu_if #(.WIDTH(8))  b8 ();

    iter_alu #(.WIDTH(32)) dut32 (.CLK(CLK), .nRST(nRST), .bus(b32.slave));
    iter_alu #(.WIDTH(8))  dut8  (.CLK(CLK), .nRST(nRST), .bus(b8.slave));

    logic        in_valid, sel8;
    logic [3:0]  op_raw;
    logic [31:0] opa, opb;

    assign b32.in_valid = in_valid & ~sel8;
    assign b8.in_valid  = in_valid & sel8;
    assign b32.op       = iter_op_t'(op_raw);
    assign b8.op        = iter_op_t'(op_raw);
    assign b32.portA    = opa;
    assign b32.portB    = opb;
    assign b8.portA     = opa[7:0];
    assign b8.portB     = opb[7:0];

    logic [63:0] o_lo, o_hi;
    logic        o_valid, o_ready;
    logic [3:0]  o_flags;

    always_comb begin
        if (sel8) begin
            o_lo    = {56'd0, b8.result_lo};
            o_hi    = {56'd0, b8.result_hi};
            o_valid = b8.out_valid;
            o_ready = b8.in_ready;
            o_flags = {b8.zero, b8.negative, b8.overflow, b8.div_by_zero};
        end else begin
            o_lo    = {32'd0, b32.result_lo};
            o_hi    = {32'd0, b32.result_hi};
            o_valid = b32.out_valid;
            o_ready = b32.in_ready;
            o_flags = {b32.zero, b32.negative, b32.overflow, b32.div_by_zero};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: true signed/unsigned integer arithmetic, then wrapped to w bits.
    function automatic void model(input int w, input logic [3:0] op, input logic [63:0] ai,
                                  input logic [63:0] bi, output logic [63:0] lo,
                                  output logic [63:0] hi, output logic [3:0] flags,
                                  output int lat);
        logic [63:0] mask, a, b, p;
        longint      sa, sb, sr, smax, smin;
        int          sh;
        logic        ovf, dbz, known;
        mask = (64'd1 << w) - 64'd1;
        a    = ai & mask;
        b    = bi & mask;
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sh   = int'(a % 64'(w));
        lo = '0; hi = '0; ovf = 1'b0; dbz = 1'b0; known = 1'b1; lat = 1;
        case (op)
            4'd0:  begin sr = sa + sb; lo = sr; ovf = (sr > smax) || (sr < smin); end
            4'd1:  begin sr = sa - sb; lo = sr; ovf = (sr > smax) || (sr < smin); end
            4'd2:  lo = a & b;
            4'd3:  lo = a | b;
            4'd4:  lo = a ^ b;
            4'd5:  lo = ~(a | b);
            4'd6:  lo = b << sh;
            4'd7:  lo = b >> sh;
            4'd8:  lo = sb >>> sh;
            4'd9:  lo = {63'd0, (sa < sb)};
            4'd10: lo = {63'd0, (a < b)};
            4'd11: begin
                sr = sa * sb; lo = sr; hi = sr >>> w;
                ovf = (sr > smax) || (sr < smin); lat = w + 2;
            end
            4'd12: begin p = a * b; lo = p; hi = p >> w; lat = w + 2; end
            4'd13, 4'd14: begin
                if (b == 0) begin
                    dbz = 1'b1; lo = mask; hi = a;
                end else if (op == 4'd13) begin
                    sr = sa / sb; lo = sr; hi = sa % sb; ovf = sr > smax; lat = w + 2;
                end else begin
                    lo = a / b; hi = a % b; lat = w + 2;
                end
            end
            default: known = 1'b0;
        endcase
        lo    = lo & mask;
        hi    = hi & mask;
        flags = {known && (lo == 0), lo[w-1], ovf, dbz};
    endfunction

    function automatic logic [31:0] rnd_opd(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return m;
            3: return (m >> 1) + 32'd1;
            4: return m >> 1;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Issues one request from a negedge in IDLE and checks latency, busy behaviour and results.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
        int          w, k, busy_bad, elat;
        logic [63:0] elo, ehi;
        logic [3:0]  ef;
        bit          seen;
        w = sel8 ? 8 : 32;
        model(w, o, 64'(a), 64'(b), elo, ehi, ef, elat);
        chk("ready_idle", 64'(o_ready), 64'd1);
        op_raw = o; opa = a; opb = b; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        op_raw = 4'($urandom); opa = $urandom; opb = $urandom;
        k = 1; busy_bad = 0; seen = 1'b0;
        @(negedge CLK);
        while (!seen && k <= 200) begin
            if (o_ready !== 1'b0) busy_bad++;
            if (o_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (poke && k == 5) in_valid = 1'b1;
                if (poke && k == 6) in_valid = 1'b0;
                @(negedge CLK);
                k++;
            end
        end
        in_valid = 1'b0;
        chk("latency", 64'(k), 64'(elat));
        chk("result_lo", o_lo, elo);
        chk("result_hi", o_hi, ehi);
        chk("flags_zn_ovf_dbz", 64'(o_flags), 64'(ef));
        chk("busy_ready_low", 64'(busy_bad), 64'd0);
        $display("txn w=%0d op=%0d a=%0h b=%0h lo=%0h hi=%0h flags=%b lat=%0d",
                 w, o, a, b, o_lo, o_hi, o_flags, k);
        @(negedge CLK);
        chk("valid_one_cycle", 64'(o_valid), 64'd0);
        chk("ready_after_done", 64'(o_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_lo"}, o_lo, 64'd0);
        chk({tag, "_hi"}, o_hi, 64'd0);
        chk({tag, "_flags"}, 64'(o_flags), 64'd0);
    endtask

    initial begin
        int vcount;
        nRST = 1'b0; in_valid = 1'b0; sel8 = 1'b0;
        op_raw = '0; opa = '0; opb = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset32");
        sel8 = 1'b1;
        #1;
        check_reset_outputs("reset8");
        sel8 = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);

        run(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run(OP_MUL,  32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        run(OP_DIVU, 32'd100,       32'd7,         1'b0);
        run(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(OP_DIV,  32'd9,         32'd0,         1'b0);
        run(4'hF,    32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        // Reset in the middle of a MULU: abandon it and never pulse out_valid.
        op_raw = OP_MULU; opa = 32'h0001_2345; opb = 32'h0006_789A; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midop_reset");
        nRST = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (o_valid === 1'b1) vcount++;
        end
        chk("no_valid_after_reset", 64'(vcount), 64'd0);

        for (int i = 0; i < 50; i++)
            run(4'($urandom_range(0, 15)), rnd_opd(32), rnd_opd(32), 1'b0);

        sel8 = 1'b1;
        #1;
        run(OP_ADD, 32'h7F, 32'h01, 1'b0);
        run(OP_MUL, 32'hFD, 32'h05, 1'b1);
        run(OP_DIV, 32'h80, 32'hFF, 1'b0);
        for (int i = 0; i < 40; i++)
            run(4'($urandom_range(0, 15)), rnd_opd(8), rnd_opd(8), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute-stage ALU.
- Handles the same logical, arithmetic, shift and compare ops with one-cycle registered latency.
- Adds iterative signed/unsigned multiply (shift-add) and divide (restoring), producing HI/LO results.
- Sits in EX beside the pipeline; the hazard unit stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle; request accepted when in_valid && in_ready.
- op  in  4  operation, iter_op_t.
- portA  in  WIDTH  operand A; shift amount for shifts.
- portB  in  WIDTH  operand B; value shifted for shifts.
- out_valid  out  1  one-cycle pulse: results valid.
- result_lo  out  WIDTH  primary result / product low / quotient.
- result_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops.
- zero  out  1  result_lo == 0.
- negative  out  1  result_lo[WIDTH-1].
- overflow  out  1  signed overflow (see Behaviour).
- div_by_zero  out  1  DIV/DIVU with portB == 0.

Behaviour:
- Reset: nRST sampled low at a CLK edge forces state IDLE. All outputs and internal registers go to 0; in_ready = 1 after reset. Reset mid-operation abandons the operation; no out_valid is produced.
- States:
  - IDLE: in_ready = 1.
    - On accept of a single-cycle op: register result, go to DONE.
    - On accept of MUL/MULU, or DIV/DIVU with portB != 0: load magnitudes, counter = 0, go to ITER.
    - On accept of DIV/DIVU with portB == 0: go to DONE with div_by_zero = 1, result_lo = all ones, result_hi = portA.
  - ITER: one radix-2 step per cycle for exactly WIDTH cycles; go to FIX when counter == WIDTH-1.
  - FIX: apply sign correction; go to DONE.
  - DONE: out_valid = 1 for this cycle only; go to IDLE.
- in_ready is 0 in ITER, FIX and DONE. in_valid in those states is ignored, not queued.
- Latency from accept edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: WIDTH+2 cycles (34 at WIDTH=32).
  - Divide by zero: 1 cycle.
- Result and flag outputs hold their values until the next accept. They are meaningful only while out_valid is high.
- Single-cycle ops:
  - SLL/SRL: portB shifted by portA[SHW-1:0]. SRA: arithmetic right shift.
  - ADD/SUB: WIDTH-bit wrap. overflow set when operand signs imply a sign-inconsistent result.
  - AND, OR, XOR, NOR.
  - SLT (signed), SLTU (unsigned): result 1 or 0.
  - Unknown encoding: result 0, flags 0, latency 1.
- MUL/MULU:
  - Full 2*WIDTH product on {result_hi, result_lo}.
  - Signed: multiply magnitudes, negate the 2*WIDTH product in FIX when sign(A) xor sign(B).
  - overflow (MUL only) = result_hi is not the sign extension of result_lo.
- DIV/DIVU:
  - Restoring division on magnitudes.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A) (truncating division).
  - MIN / -1 gives lo = MIN, hi = 0, overflow = 1.
- overflow is 0 for all other ops. div_by_zero is 0 except the case above.

Decomposition:
- cpu_types_pkg gains:
  - iter_op_t enum (4-bit): ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, MUL, MULU, DIV, DIVU.
  - iter_state_t enum: IDLE, ITER, FIX, DONE.
- One combinational sub-module, alu_comb: WIDTH-parametrised single-cycle datapath producing result and overflow. iter_alu registers its output.
- The FSM, counter and mul/div datapath stay in iter_alu.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept; result_lo 0x80000000, overflow 1, negative 1, zero 0.
- MUL -3 * 5 -> out_valid at cycle 34; hi 0xFFFFFFFF, lo 0xFFFFFFF1, overflow 0. in_ready low cycles 1-34. A second in_valid at cycle 5 is ignored.
- DIVU 100 / 7 -> lo 14, hi 2 at cycle 34.
- DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0, overflow 1.
- DIV 9 / 0 -> out_valid at cycle 1; div_by_zero 1, lo 0xFFFFFFFF, hi 9.
- nRST low at cycle 10 of a MULU -> next cycle: IDLE, in_ready 1, all outputs 0; no out_valid pulse follows.
- Repeat the ADD and MUL cases at WIDTH=8: MUL -3 * 5 -> hi 0xFF, lo 0xF1 at cycle 10.
